// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the AAP decode_control slice.
//   - instruction class / opcode constants for flow control
//   - PC-select codes driven on pcjumpenable
//   - decode FSM state enum
package decode_pkg;

  localparam logic [1:0] CLASS_FLOW = 2'd2;
  localparam logic [3:0] OP_BRA     = 4'd0;
  localparam logic [3:0] OP_JMP     = 4'd1;

  localparam logic [2:0] PCSEL_INC  = 3'd0;
  localparam logic [2:0] PCSEL_REL  = 3'd1;
  localparam logic [2:0] PCSEL_ABS  = 3'd2;

  typedef enum logic [1:0] {
    S_WORD    = 2'd0,
    S_SECOND  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational field slicing of an AAP instruction.
// Ports:
//   first_w    in  16  first (or only) instruction word
//   second_w   in  16  second word, meaningful when long_mode = 1
//   long_mode  in  1   first_w/second_w form a complete 32-bit instruction
//   cls        out 2   first_w[14:13]
//   opcode     out 4   first_w[12:9]
//   rd/ra/rb   out 3   first_w[8:6] / [5:3] / [2:0]
//   imm        out 16  second_w in long mode, else 0
//   is_long    out 1   first_w[15]: a second word follows this one
//   is_illegal out 1   flow-class opcode that has no defined meaning
module decode_fields
  import decode_pkg::*;
(
  input  logic [15:0] first_w,
  input  logic [15:0] second_w,
  input  logic        long_mode,
  output logic [1:0]  cls,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [15:0] imm,
  output logic        is_long,
  output logic        is_illegal
);

  always_comb begin
    cls     = first_w[14:13];
    opcode  = first_w[12:9];
    rd      = first_w[8:6];
    ra      = first_w[5:3];
    rb      = first_w[2:0];
    imm     = long_mode ? second_w : 16'h0000;
    is_long = first_w[15];
    // JMP needs its second word for the target, so the short form is illegal.
    is_illegal = (cls == CLASS_FLOW) &&
                 ((opcode > OP_JMP) || ((opcode == OP_JMP) && !long_mode));
  end

endmodule

// File: rtl/decode_control.sv
// decode_control: consumer end of the fetch instruction window. Assembles
// 16/32-bit instructions, registers decoded fields for execute and drives
// PC-steering back to fetch.
// Ports:
//   clock, reset_n       clock / synchronous active-low reset
//   fetchoutput   in 32  [31:16] older word, [15:0] newest word
//   pcjumpenable  out 3  0 increment, 1 relative, 2 absolute
//   pcchange      out 9  relative offset (pcjumpenable = 1)
//   pclocation    out PC_W absolute target (pcjumpenable = 2)
//   flush         out 1  one-cycle redirect pulse
//   dec_*         out    registered decoded instruction fields
//   dbg_state     out    current FSM state
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to redirect illegal
// opcodes to TRAP_VECTOR instead of passing them through.
module decode_control
  import decode_pkg::*;
#(
  parameter int              PC_W        = 20,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              DISCARD_N   = 2,
  parameter logic [19:0]     TRAP_VECTOR = 20'h00010
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     fetchoutput,
  output logic [2:0]      pcjumpenable,
  output logic [8:0]      pcchange,
  output logic [PC_W-1:0] pclocation,
  output logic            flush,
  output logic            dec_valid,
  output logic            dec_long,
  output logic [1:0]      dec_class,
  output logic [3:0]      dec_opcode,
  output logic [2:0]      dec_rd,
  output logic [2:0]      dec_ra,
  output logic [2:0]      dec_rb,
  output logic [15:0]     dec_imm,
  output logic [PC_W-1:0] dec_pc,
  output state_t          dbg_state
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Handshake: none. fetch presents a new window every cycle; dec_valid
  // marks the cycles whose registered dec_* fields carry an instruction,
  // and execute must accept it in that cycle.

  state_t          state_q, state_d;
  logic [PC_W-1:0] word_pc_q, word_pc_d;
  logic [PC_W-1:0] first_pc_q, first_pc_d;
  logic [1:0]      cnt_q, cnt_d;

  logic [2:0]      jsel_q, jsel_d;
  logic [8:0]      pcchange_q, pcchange_d;
  logic [PC_W-1:0] pclocation_q, pclocation_d;
  logic            flush_q, flush_d;
  logic            valid_q, valid_d;
  logic            long_q, long_d;
  logic [1:0]      class_q, class_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [2:0]      rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [15:0]     imm_q, imm_d;
  logic [PC_W-1:0] dec_pc_q, dec_pc_d;

  logic            long_mode;
  logic [15:0]     first_w;
  logic [1:0]      f_cls;
  logic [3:0]      f_opcode;
  logic [2:0]      f_rd, f_ra, f_rb;
  logic [15:0]     f_imm;
  logic            f_is_long, f_illegal;
  logic [19:0]     jmp_raw;

  // In S_SECOND the older word of the window is the first instruction word.
  assign long_mode = (state_q == S_SECOND);
  assign first_w   = long_mode ? fetchoutput[31:16] : fetchoutput[15:0];
  assign jmp_raw   = {first_w[3:0], fetchoutput[15:0]};

  decode_fields u_fields (
    .first_w    (first_w),
    .second_w   (fetchoutput[15:0]),
    .long_mode  (long_mode),
    .cls        (f_cls),
    .opcode     (f_opcode),
    .rd         (f_rd),
    .ra         (f_ra),
    .rb         (f_rb),
    .imm        (f_imm),
    .is_long    (f_is_long),
    .is_illegal (f_illegal)
  );

  logic            issue;
  logic [PC_W-1:0] issue_pc;

  always_comb begin
    state_d      = state_q;
    word_pc_d    = word_pc_q + 1'b1;
    first_pc_d   = first_pc_q;
    cnt_d        = cnt_q;
    jsel_d       = PCSEL_INC;
    flush_d      = 1'b0;
    valid_d      = 1'b0;
    pcchange_d   = pcchange_q;
    pclocation_d = pclocation_q;
    long_d       = long_q;
    class_d      = class_q;
    opcode_d     = opcode_q;
    rd_d         = rd_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    imm_d        = imm_q;
    dec_pc_d     = dec_pc_q;
    issue        = 1'b0;
    issue_pc     = word_pc_q;

    case (state_q)
      S_WORD: begin
        if (f_is_long) begin
          state_d    = S_SECOND;
          first_pc_d = word_pc_q;
        end else begin
          issue = 1'b1;
        end
      end
      S_SECOND: begin
        issue    = 1'b1;
        issue_pc = first_pc_q;
        state_d  = S_WORD;
      end
      S_DISCARD: begin
        // Hold word_pc at the redirect target while stale windows drain,
        // so the first accepted word after discard is the target word.
        word_pc_d = word_pc_q;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == 2'd1) state_d = S_WORD;
      end
      default: state_d = S_WORD;
    endcase

    if (issue) begin
      valid_d  = 1'b1;
      long_d   = long_mode;
      class_d  = f_cls;
      opcode_d = f_opcode;
      rd_d     = f_rd;
      ra_d     = f_ra;
      rb_d     = f_rb;
      imm_d    = f_imm;
      dec_pc_d = issue_pc;
      if (f_cls == CLASS_FLOW && f_opcode == OP_BRA) begin
        jsel_d     = PCSEL_REL;
        pcchange_d = first_w[8:0];
        flush_d    = 1'b1;
        state_d    = S_DISCARD;
        cnt_d      = 2'(DISCARD_N);
        word_pc_d  = issue_pc + {{(PC_W-9){first_w[8]}}, first_w[8:0]};
      end else if (f_cls == CLASS_FLOW && f_opcode == OP_JMP && long_mode) begin
        jsel_d       = PCSEL_ABS;
        pclocation_d = PC_W'(jmp_raw);
        flush_d      = 1'b1;
        state_d      = S_DISCARD;
        cnt_d        = 2'(DISCARD_N);
        word_pc_d    = PC_W'(jmp_raw);
      end else if (f_illegal && TRAP_EN) begin
        valid_d      = 1'b0;
        jsel_d       = PCSEL_ABS;
        pclocation_d = PC_W'(TRAP_VECTOR);
        flush_d      = 1'b1;
        state_d      = S_DISCARD;
        cnt_d        = 2'(DISCARD_N);
        word_pc_d    = PC_W'(TRAP_VECTOR);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_WORD;
      word_pc_q    <= RESET_PC;
      first_pc_q   <= '0;
      cnt_q        <= '0;
      jsel_q       <= PCSEL_INC;
      pcchange_q   <= '0;
      pclocation_q <= '0;
      flush_q      <= 1'b0;
      valid_q      <= 1'b0;
      long_q       <= 1'b0;
      class_q      <= '0;
      opcode_q     <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      imm_q        <= '0;
      dec_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      word_pc_q    <= word_pc_d;
      first_pc_q   <= first_pc_d;
      cnt_q        <= cnt_d;
      jsel_q       <= jsel_d;
      pcchange_q   <= pcchange_d;
      pclocation_q <= pclocation_d;
      flush_q      <= flush_d;
      valid_q      <= valid_d;
      long_q       <= long_d;
      class_q      <= class_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      imm_q        <= imm_d;
      dec_pc_q     <= dec_pc_d;
    end
  end

  assign pcjumpenable = jsel_q;
  assign pcchange     = pcchange_q;
  assign pclocation   = pclocation_q;
  assign flush        = flush_q;
  assign dec_valid    = valid_q;
  assign dec_long     = long_q;
  assign dec_class    = class_q;
  assign dec_opcode   = opcode_q;
  assign dec_rd       = rd_q;
  assign dec_ra       = ra_q;
  assign dec_rb       = rb_q;
  assign dec_imm      = imm_q;
  assign dec_pc       = dec_pc_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_decode_control.sv
// tb_decode_control: directed self-checking bench for decode_control.
module tb_decode_control;
  import decode_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [31:0] fetchoutput;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [19:0] pclocation;
  logic        flush;
  logic        dec_valid;
  logic        dec_long;
  logic [1:0]  dec_class;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_rd, dec_ra, dec_rb;
  logic [15:0] dec_imm;
  logic [19:0] dec_pc;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  decode_control dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetchoutput  (fetchoutput),
    .pcjumpenable (pcjumpenable),
    .pcchange     (pcchange),
    .pclocation   (pclocation),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_long     (dec_long),
    .dec_class    (dec_class),
    .dec_opcode   (dec_opcode),
    .dec_rd       (dec_rd),
    .dec_ra       (dec_ra),
    .dec_rb       (dec_rb),
    .dec_imm      (dec_imm),
    .dec_pc       (dec_pc),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present one window, then sample 1 time unit after the edge
  task automatic step(input logic [31:0] w);
    fetchoutput = w;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, "_jsel"}, 32'(pcjumpenable), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    fetchoutput = 32'h0;
    step(32'h0);
    step(32'h0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_jsel", 32'(pcjumpenable), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc", 32'(dec_pc), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_WORD));
    reset_n = 1'b1;

    // short instruction at pc 0
    step({16'h0000, 16'h0A53});
    chk("s_valid", 32'(dec_valid), 32'd1);
    chk("s_class", 32'(dec_class), 32'd0);
    chk("s_op", 32'(dec_opcode), 32'd5);
    chk("s_rd", 32'(dec_rd), 32'd1);
    chk("s_ra", 32'(dec_ra), 32'd2);
    chk("s_rb", 32'(dec_rb), 32'd3);
    chk("s_pc", 32'(dec_pc), 32'd0);
    chk("s_jsel", 32'(pcjumpenable), 32'd0);
    chk("s_long", 32'(dec_long), 32'd0);

    // long form: first word at pc 1, second at pc 2
    step({16'h0A53, 16'h8000});
    chk("l1_valid", 32'(dec_valid), 32'd0);
    step({16'h8000, 16'h1234});
    chk("l_valid", 32'(dec_valid), 32'd1);
    chk("l_long", 32'(dec_long), 32'd1);
    chk("l_imm", 32'(dec_imm), 32'h1234);
    chk("l_pc", 32'(dec_pc), 32'd1);
    step({16'h1234, 16'h0000});
    chk("l_next_long", 32'(dec_long), 32'd0);
    chk("l_next_pc", 32'(dec_pc), 32'd3);
    chk("l_next_imm", 32'(dec_imm), 32'd0);

    // filler up to pc 9
    for (int i = 4; i < 10; i++) begin
      step(32'h0);
      chk("fill_pc", 32'(dec_pc), 32'(i));
    end

    // BRA -4 at pc 10 -> target 6
    step({16'h0000, 16'h41FC});
    chk("bra_valid", 32'(dec_valid), 32'd1);
    chk("bra_jsel", 32'(pcjumpenable), 32'd1);
    chk("bra_off", 32'(pcchange), 32'h1FC);
    chk("bra_flush", 32'(flush), 32'd1);
    chk("bra_pc", 32'(dec_pc), 32'd10);
    step({16'h41FC, 16'h41FC});
    chk_idle("bra_d1");
    step({16'h41FC, 16'h41FC});
    chk_idle("bra_d2");
    step({16'h0000, 16'h0A53});
    chk("bra_tgt_valid", 32'(dec_valid), 32'd1);
    chk("bra_tgt_pc", 32'(dec_pc), 32'd6);
    chk("bra_tgt_jsel", 32'(pcjumpenable), 32'd0);

    // long JMP at pc 7 -> 0x50040
    step({16'h0A53, 16'hC205});
    chk("jmp1_valid", 32'(dec_valid), 32'd0);
    step({16'hC205, 16'h0040});
    chk("jmp_valid", 32'(dec_valid), 32'd1);
    chk("jmp_jsel", 32'(pcjumpenable), 32'd2);
    chk("jmp_loc", 32'(pclocation), 32'h50040);
    chk("jmp_flush", 32'(flush), 32'd1);
    chk("jmp_pc", 32'(dec_pc), 32'd7);
    step({16'h0040, 16'h0000});
    chk_idle("jmp_d1");
    step(32'h0);
    chk_idle("jmp_d2");
    step({16'h0000, 16'h0A53});
    chk("jmp_tgt_pc", 32'(dec_pc), 32'h50040);
    chk("jmp_tgt_valid", 32'(dec_valid), 32'd1);

    // reset while in S_SECOND
    step({16'h0A53, 16'h8000});
    chk("rs_state", 32'(dbg_state), 32'(S_SECOND));
    reset_n = 1'b0;
    step({16'h8000, 16'h1234});
    chk("rs_valid", 32'(dec_valid), 32'd0);
    chk("rs_long", 32'(dec_long), 32'd0);
    reset_n = 1'b1;
    step({16'h1234, 16'h0A53});
    chk("rs_new_valid", 32'(dec_valid), 32'd1);
    chk("rs_new_long", 32'(dec_long), 32'd0);
    chk("rs_new_pc", 32'(dec_pc), 32'd0);

    // BRA offset 0 at pc 1: self-loop
    step({16'h0A53, 16'h4000});
    chk("self_jsel", 32'(pcjumpenable), 32'd1);
    chk("self_off", 32'(pcchange), 32'd0);
    chk("self_flush", 32'(flush), 32'd1);
    step(32'h0);
    chk_idle("self_d1");
    step(32'h0);
    chk_idle("self_d2");

    // illegal opcode 3 at pc 1
    step({16'h0000, 16'h4600});
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_valid", 32'(dec_valid), 32'd0);
    chk("ill_jsel", 32'(pcjumpenable), 32'd2);
    chk("ill_loc", 32'(pclocation), 32'h00010);
    chk("ill_flush", 32'(flush), 32'd1);
    step(32'h0);
    chk_idle("ill_d1");
    step(32'h0);
    chk_idle("ill_d2");
    step({16'h0000, 16'h0A53});
    chk("ill_tgt_pc", 32'(dec_pc), 32'h00010);
`else
    chk("ill_valid", 32'(dec_valid), 32'd1);
    chk("ill_jsel", 32'(pcjumpenable), 32'd0);
    chk("ill_flush", 32'(flush), 32'd0);
    chk("ill_op", 32'(dec_opcode), 32'd3);
    chk("ill_pc", 32'(dec_pc), 32'd1);
    // short-form JMP at pc 2 is illegal: no redirect
    step({16'h4600, 16'h4200});
    chk("sjmp_valid", 32'(dec_valid), 32'd1);
    chk("sjmp_jsel", 32'(pcjumpenable), 32'd0);
    chk("sjmp_flush", 32'(flush), 32'd0);
    chk("sjmp_pc", 32'(dec_pc), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
